// File: rtl/timer_irq_controller_if.sv
// Avalon-style slave bus shared by the timer interrupt controller register file.
// The master modport belongs to the interconnect; the slave modport to the controller.
interface timer_irq_controller_if;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (output read_n, write_n, address, writeData, input readData);
  modport slave  (input read_n, write_n, address, writeData, output readData);
endinterface

// File: rtl/timer_irq_controller.sv
// Latches timer interrupt edges as pending and arbitrates them onto one CPU line with claim/complete.
// Define TIMER_IRQ_RR_EN for round-robin arbitration; otherwise the lowest pending index wins.
module timer_irq_controller #(
  parameter int NUM_TIMERS = 4,
  parameter int ID_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  timer_irq_controller_if.slave bus,
  input  logic [NUM_TIMERS-1:0] tim_irq,
  output logic                  cpu_irq,
  output logic [ID_W-1:0]       cpu_irq_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_MASK     = 3'd1;
  localparam logic [2:0] OFF_CTRL     = 3'd2;
  localparam logic [2:0] OFF_CLAIM    = 3'd3;
  localparam logic [2:0] OFF_COMPLETE = 3'd4;

  state_t                state, state_nxt;
  logic [NUM_TIMERS-1:0] pending, pending_nxt;
  logic [NUM_TIMERS-1:0] mask;
  logic                  enable;
  logic [NUM_TIMERS-1:0] tim_irq_q;
  logic [ID_W-1:0]       winner, winner_nxt;
  logic [ID_W-1:0]       search_start;
  logic                  claim_fire;
  logic [31:0]           rd_mux;

  logic [2:0]            offset;
  logic                  rd_en;
  logic                  wr_en;
  logic                  claim_rd;
  logic                  complete_wr;
  logic [NUM_TIMERS-1:0] irq_edge;
  logic [NUM_TIMERS-1:0] eligible;
  logic [NUM_TIMERS-1:0] winner_onehot;
  logic                  unused_bus_bits;

  // A simultaneous read and write executes only the write, so the read path is qualified by write_n.
  assign offset          = bus.address[4:2];
  assign rd_en           = !bus.read_n && bus.write_n;
  assign wr_en           = !bus.write_n;
  assign claim_rd        = rd_en && (offset == OFF_CLAIM);
  assign complete_wr     = wr_en && (offset == OFF_COMPLETE) && (bus.writeData[ID_W-1:0] == winner);
  assign irq_edge        = tim_irq & ~tim_irq_q;
  assign eligible        = (enable && (state != SERVICE)) ? (pending & mask) : '0;
  assign winner_onehot   = NUM_TIMERS'(1) << winner;
  assign unused_bus_bits = ^{bus.address[31:5], bus.address[1:0], bus.writeData};

  // Rotate the request vector so the search begins at 'start', then take the first set bit.
  function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_TIMERS-1:0] req,
                                                  input logic [ID_W-1:0] start);
    logic [NUM_TIMERS-1:0] rot;
    logic [ID_W-1:0]       result;
    logic                  found;
    rot    = NUM_TIMERS'({req, req} >> start);
    result = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (!found && rot[k]) begin
        result = ID_W'((int'(start) + k) % NUM_TIMERS);
        found  = 1'b1;
      end
    end
    return result;
  endfunction

`ifdef TIMER_IRQ_RR_EN
  localparam logic RR_MODE = 1'b1;
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (claim_fire) begin
      rr_ptr <= (winner == ID_W'(NUM_TIMERS - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign search_start = rr_ptr;
`else
  localparam logic RR_MODE = 1'b0;
  assign search_start = '0;
`endif

  // Once latched in REQ the winner is held; only a claim or its loss of eligibility moves on.
  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    claim_fire = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt  = REQ;
          winner_nxt = pick_winner(eligible, search_start);
        end
      end
      REQ: begin
        if (claim_rd) begin
          state_nxt  = SERVICE;
          claim_fire = 1'b1;
        end else if (!(|(eligible & winner_onehot))) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (complete_wr) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // New edges are OR-ed in last so they survive both a W1C and a claim in the same cycle.
  always_comb begin
    pending_nxt = pending;
    if (wr_en && (offset == OFF_PENDING)) begin
      pending_nxt = pending_nxt & ~bus.writeData[NUM_TIMERS-1:0];
    end
    if (claim_fire) begin
      pending_nxt = pending_nxt & ~winner_onehot;
    end
    pending_nxt = pending_nxt | irq_edge;
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_PENDING: rd_mux = 32'(pending);
      OFF_MASK:    rd_mux = 32'(mask);
      OFF_CTRL:    rd_mux = {30'd0, RR_MODE, enable};
      OFF_CLAIM:   rd_mux = (state == REQ) ? 32'(winner) : 32'hFFFF_FFFF;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      winner        <= '0;
      pending       <= '0;
      mask          <= '0;
      enable        <= 1'b0;
      tim_irq_q     <= '0;
      bus.readData  <= '0;
      cpu_irq       <= 1'b0;
      cpu_irq_id    <= '0;
    end else begin
      state     <= state_nxt;
      winner    <= winner_nxt;
      pending   <= pending_nxt;
      tim_irq_q <= tim_irq;
      if (wr_en && (offset == OFF_MASK)) begin
        mask <= bus.writeData[NUM_TIMERS-1:0];
      end
      if (wr_en && (offset == OFF_CTRL)) begin
        enable <= bus.writeData[0];
      end
      if (!bus.read_n) begin
        bus.readData <= bus.write_n ? rd_mux : '0;
      end
      cpu_irq    <= (state_nxt == REQ);
      cpu_irq_id <= (state_nxt == REQ) ? winner_nxt : '0;
    end
  end

endmodule

// File: tb/tb_timer_irq_controller.sv
// Scoreboard bench: stimulus pushes expected read data and cpu_irq edge events into queues,
// and a negedge monitor pops and compares them whenever the DUT presents a response.
module tb_timer_irq_controller;

  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_MASK     = 3'd1;
  localparam logic [2:0] OFF_CTRL     = 3'd2;
  localparam logic [2:0] OFF_CLAIM    = 3'd3;
  localparam logic [2:0] OFF_COMPLETE = 3'd4;
`ifdef TIMER_IRQ_RR_EN
  localparam logic [31:0] CTRL_ON = 32'h3;
`else
  localparam logic [31:0] CTRL_ON = 32'h1;
`endif

  typedef struct packed {
    logic       rise;
    logic [2:0] id;
  } irq_ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] tim_irq;
  logic       cpu_irq;
  logic [2:0] cpu_irq_id;

  timer_irq_controller_if bus();

  timer_irq_controller #(.NUM_TIMERS(4), .ID_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tim_irq    (tim_irq),
    .cpu_irq    (cpu_irq),
    .cpu_irq_id (cpu_irq_id)
  );

  int          total;
  int          bad;
  logic [31:0] rd_exp[$];
  string       rd_name[$];
  irq_ev_t     irq_q[$];
  logic        rd_seen;
  logic        prev_irq;
  logic        cur_irq;
  logic [31:0] mon_exp;
  string       mon_name;
  irq_ev_t     mon_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // One bus cycle; tim_irq bits in irq_set rise together with the strobes.
  task automatic applyStimulus(input bit do_read, input bit do_write, input logic [2:0] off,
                               input logic [31:0] data, input logic [3:0] irq_set,
                               input logic [31:0] exp_rd, input string name);
    logic [3:0] saved;
    @(posedge clk);
    #1;
    saved         = tim_irq;
    tim_irq       = tim_irq | irq_set;
    bus.address   = {27'd0, off, 2'b00};
    bus.writeData = data;
    bus.read_n    = !do_read;
    bus.write_n   = !do_write;
    if (do_read) begin
      rd_exp.push_back(exp_rd);
      rd_name.push_back(name);
    end
    @(posedge clk);
    #1;
    bus.read_n  = 1'b1;
    bus.write_n = 1'b1;
    tim_irq     = saved;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, off, data, 4'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp_rd, input string name);
    applyStimulus(1'b1, 1'b0, off, 32'd0, 4'b0, exp_rd, name);
  endtask

  task automatic pulseIrq(input logic [3:0] v);
    @(posedge clk);
    #1 tim_irq = v;
    @(posedge clk);
    #1 tim_irq = 4'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectIrq(input logic rise, input logic [2:0] id);
    irq_q.push_back('{rise: rise, id: id});
  endtask

  task automatic waitIrqDrained(input int budget, input string name);
    int n;
    n = 0;
    while (irq_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (irq_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s: %0d irq events still outstanding, required 0", name, irq_q.size());
      irq_q.delete();
    end
  endtask

  always @(posedge clk) rd_seen = (bus.read_n === 1'b0) && !rst;

  initial prev_irq = 1'b0;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_exp.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_read: got %h, required no read", bus.readData);
      end else begin
        mon_exp  = rd_exp.pop_front();
        mon_name = rd_name.pop_front();
        checkOutput(mon_name, bus.readData, mon_exp);
      end
    end
    cur_irq = (cpu_irq === 1'b1);
    if (cur_irq != prev_irq) begin
      if (irq_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_irq_edge: got cpu_irq=%b id=%0d, required no change", cur_irq, cpu_irq_id);
      end else begin
        mon_ev = irq_q.pop_front();
        checkOutput("irq_edge_dir", 32'(cur_irq), 32'(mon_ev.rise));
        checkOutput(cur_irq ? "irq_id" : "irq_id_clear", 32'(cpu_irq_id),
                    cur_irq ? 32'(mon_ev.id) : 32'd0);
      end
    end
    prev_irq = cur_irq;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    tim_irq       = 4'b0;
    bus.read_n    = 1'b1;
    bus.write_n   = 1'b1;
    bus.address   = 32'd0;
    bus.writeData = 32'd0;
    idle(3);
    rst = 1'b0;
    idle(1);

    $display("[TB] reset state");
    checkOutput("reset_readData", bus.readData, 32'd0);
    checkOutput("reset_cpu_irq", 32'(cpu_irq), 32'd0);
    checkOutput("reset_cpu_irq_id", 32'(cpu_irq_id), 32'd0);
    rd(OFF_PENDING, 32'd0, "reset_pending");
    rd(OFF_MASK, 32'd0, "reset_mask");
    rd(OFF_CTRL, 32'd0, "reset_ctrl");
    rd(3'd6, 32'd0, "unmapped_read");

    $display("[TB] configuration");
    wr(OFF_MASK, 32'hF);
    wr(OFF_CTRL, 32'h1);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(OFF_CTRL, CTRL_ON, "ctrl_enabled");
    rd(OFF_MASK, 32'hF, "mask_all");

`ifdef TIMER_IRQ_RR_EN
    $display("[TB] round-robin order");
    expectIrq(1'b1, 3'd0);
    pulseIrq(4'b1111);
    waitIrqDrained(4, "rr_first_req");
    for (int i = 0; i < 4; i++) begin
      expectIrq(1'b0, 3'd0);
      rd(OFF_CLAIM, 32'(i), "rr_claim_seq");
      if (i < 3) expectIrq(1'b1, 3'(i + 1));
      wr(OFF_COMPLETE, 32'(i));
      waitIrqDrained(4, "rr_next_req");
    end
    expectIrq(1'b1, 3'd1);
    pulseIrq(4'b0010);
    waitIrqDrained(4, "rr_single_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd1, "rr_claim_1");
    wr(OFF_COMPLETE, 32'd1);
    expectIrq(1'b1, 3'd2);
    pulseIrq(4'b1111);
    waitIrqDrained(4, "rr_ptr2_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd2, "rr_claim_from_ptr2");
    expectIrq(1'b1, 3'd3);
    wr(OFF_COMPLETE, 32'd2);
    waitIrqDrained(4, "rr_after_ptr2");
    expectIrq(1'b0, 3'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    waitIrqDrained(4, "rr_reset_drop");
    wr(OFF_MASK, 32'hF);
    wr(OFF_CTRL, 32'h1);
`endif

    $display("[TB] single source");
    expectIrq(1'b1, 3'd2);
    pulseIrq(4'b0100);
    waitIrqDrained(3, "single_req_latency");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd2, "single_claim");
    rd(OFF_PENDING, 32'd0, "single_pending_cleared");
    rd(OFF_CLAIM, 32'hFFFF_FFFF, "claim_in_service");
    wr(OFF_COMPLETE, 32'd2);
    idle(3);

    $display("[TB] fixed priority");
    expectIrq(1'b1, 3'd1);
    pulseIrq(4'b1010);
    waitIrqDrained(4, "prio_first_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd1, "prio_claim_1");
    rd(OFF_PENDING, 32'h8, "prio_pending_3_left");
    expectIrq(1'b1, 3'd3);
    wr(OFF_COMPLETE, 32'd1);
    waitIrqDrained(4, "prio_second_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd3, "prio_claim_3");
    wr(OFF_COMPLETE, 32'd3);
    rd(OFF_PENDING, 32'd0, "prio_pending_empty");

    $display("[TB] masking");
    wr(OFF_MASK, 32'h1);
    pulseIrq(4'b0010);
    idle(3);
    rd(OFF_PENDING, 32'h2, "masked_pending");
    expectIrq(1'b1, 3'd1);
    wr(OFF_MASK, 32'h3);
    waitIrqDrained(4, "unmask_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd1, "unmask_claim");
    wr(OFF_COMPLETE, 32'd1);

    $display("[TB] withdraw and misuse");
    expectIrq(1'b1, 3'd0);
    pulseIrq(4'b0001);
    waitIrqDrained(4, "withdraw_req");
    expectIrq(1'b0, 3'd0);
    wr(OFF_PENDING, 32'h1);
    waitIrqDrained(4, "withdraw_drop");
    rd(OFF_CLAIM, 32'hFFFF_FFFF, "claim_in_idle");
    rd(OFF_PENDING, 32'd0, "withdraw_pending");
    expectIrq(1'b1, 3'd0);
    pulseIrq(4'b0001);
    waitIrqDrained(4, "mismatch_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd0, "mismatch_claim");
    wr(OFF_COMPLETE, 32'd3);
    pulseIrq(4'b0010);
    idle(4);
    rd(OFF_PENDING, 32'h2, "mismatch_still_service");
    expectIrq(1'b1, 3'd1);
    wr(OFF_COMPLETE, 32'd0);
    waitIrqDrained(4, "after_complete_req");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd1, "after_complete_claim");
    wr(OFF_COMPLETE, 32'd1);

    $display("[TB] clear/set collisions");
    wr(OFF_MASK, 32'h0);
    pulseIrq(4'b0100);
    applyStimulus(1'b0, 1'b1, OFF_PENDING, 32'h4, 4'b0100, 32'd0, "w1c_with_edge");
    rd(OFF_PENDING, 32'h4, "set_wins_over_w1c");
    wr(OFF_PENDING, 32'h4);
    rd(OFF_PENDING, 32'h0, "w1c_alone");
    @(posedge clk);
    #1 tim_irq = 4'b0001;
    idle(2);
    wr(OFF_PENDING, 32'h1);
    idle(2);
    rd(OFF_PENDING, 32'h0, "held_level_no_reset");
    tim_irq = 4'b0000;
    applyStimulus(1'b1, 1'b1, OFF_MASK, 32'h5, 4'b0, 32'd0, "read_write_same_cycle");
    rd(OFF_MASK, 32'h5, "write_wins_same_cycle");

    $display("[TB] edge during claim");
    wr(OFF_MASK, 32'hF);
    expectIrq(1'b1, 3'd0);
    pulseIrq(4'b0001);
    waitIrqDrained(4, "edge_claim_req");
    expectIrq(1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, OFF_CLAIM, 32'd0, 4'b0001, 32'd0, "claim_with_edge");
    rd(OFF_PENDING, 32'h1, "edge_survives_claim");
    expectIrq(1'b1, 3'd0);
    wr(OFF_COMPLETE, 32'd0);
    waitIrqDrained(4, "edge_claim_rerequest");
    expectIrq(1'b0, 3'd0);
    rd(OFF_CLAIM, 32'd0, "edge_claim_second");
    wr(OFF_COMPLETE, 32'd0);

    $display("[TB] reset during REQ");
    expectIrq(1'b1, 3'd1);
    pulseIrq(4'b0010);
    waitIrqDrained(4, "reset_req");
    expectIrq(1'b0, 3'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    rst = 1'b0;
    waitIrqDrained(4, "reset_drop");
    rd(OFF_PENDING, 32'd0, "post_reset_pending");
    rd(OFF_MASK, 32'd0, "post_reset_mask");
    rd(OFF_CTRL, 32'd0, "post_reset_ctrl");

    idle(3);
    while (rd_exp.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL missing_read %s: got no response, required %h", rd_name.pop_front(), rd_exp.pop_front());
    end
    while (irq_q.size() != 0) begin
      mon_ev = irq_q.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL missing_irq_edge: got none, required rise=%b id=%0d", mon_ev.rise, mon_ev.id);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
